// File: rtl/seq_mul_shift_add.sv
// Sequential shift-add multiplier: controller FSM and datapath in one block.
// Operates on magnitudes and applies the sign once, on entry to DONE.
module seq_mul_shift_add #(
    parameter int unsigned WIDTH  = 8,
    parameter bit          SIGNED = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   a_q, a_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic                 neg_q, neg_d;

    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic                 sign;

    // The most negative operand's magnitude still fits as a WIDTH-bit unsigned value.
    always_comb begin
        a_mag = (SIGNED && a_in[WIDTH-1]) ? -a_in : a_in;
        b_mag = (SIGNED && b_in[WIDTH-1]) ? -b_in : b_in;
        sign  = SIGNED ? (a_in[WIDTH-1] ^ b_in[WIDTH-1]) : 1'b0;
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        neg_d     = neg_q;
        product_d = product_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    a_d     = {{WIDTH{1'b0}}, a_mag};
                    b_d     = b_mag;
                    acc_d   = '0;
                    neg_d   = sign;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (b_q == '0) begin
                    product_d = neg_q ? -acc_q : acc_q;
                    state_d   = StDone;
                end else begin
                    if (b_q[0]) begin
                        acc_d = acc_q + a_q;
                    end
                    a_d = a_q << 1;
                    b_d = b_q >> 1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            neg_q     <= neg_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q == StCalc);
    assign done    = (state_q == StDone);
    assign product = product_q;

endmodule

// File: tb/tb_seq_mul_shift_add.sv
// Bench for seq_mul_shift_add: an unsigned and a signed instance share the same stimulus and are
// compared against plain-integer products and bit-length latencies.
module tb_seq_mul_shift_add;

    localparam int unsigned W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           abort;
    logic [W-1:0]   a_in;
    logic [W-1:0]   b_in;
    logic           busy_u, done_u, busy_s, done_s;
    logic [2*W-1:0] prod_u, prod_s;

    logic [2*W-1:0] exp_u, exp_s;
    int             vectors = 0;
    int             errors  = 0;

    always #5 clk = ~clk;

    seq_mul_shift_add #(.WIDTH(W), .SIGNED(1'b0)) u_dut_u (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .a_in    (a_in),
        .b_in    (b_in),
        .busy    (busy_u),
        .done    (done_u),
        .product (prod_u)
    );

    seq_mul_shift_add #(.WIDTH(W), .SIGNED(1'b1)) u_dut_s (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .a_in    (a_in),
        .b_in    (b_in),
        .busy    (busy_s),
        .done    (done_s),
        .product (prod_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int bitlen(input int v);
        int n = 0;
        while (v > 0) begin
            n++;
            v = v >> 1;
        end
        return n;
    endfunction

    function automatic int to_signed(input logic [W-1:0] v);
        return v[W-1] ? int'(v) - (1 << W) : int'(v);
    endfunction

    // One full multiply on both instances; optionally pulses a foreign start mid-CALC.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit glitch);
        int          sa, sb, ku, ks, lat_u, lat_s, bc_u, bc_s;
        bit          moved_u, moved_s;
        logic [1:0]  first_u, first_s;
        logic [2*W-1:0] new_u, new_s;
        sa    = to_signed(a);
        sb    = to_signed(b);
        new_u = (2*W)'(int'(a) * int'(b));
        new_s = (2*W)'(sa * sb);
        ku    = bitlen(int'(b));
        ks    = bitlen(sb < 0 ? -sb : sb);
        lat_u = -1; lat_s = -1; bc_u = 0; bc_s = 0;
        moved_u = 1'b0; moved_s = 1'b0;
        first_u = 2'b00; first_s = 2'b00;

        @(negedge clk);
        start = 1'b1; a_in = a; b_in = b;
        @(negedge clk);
        start = 1'b0; a_in = W'($urandom); b_in = W'($urandom);
        for (int e = 0; e <= int'(W) + 2; e++) begin
            if (e == 0) begin
                first_u = {busy_u, done_u};
                first_s = {busy_s, done_s};
            end
            if (glitch && e == 1) begin
                start = 1'b1; a_in = 8'hFF; b_in = 8'h7F;
            end
            if (glitch && e == 2) start = 1'b0;
            if (done_u && lat_u < 0) lat_u = e;
            if (done_s && lat_s < 0) lat_s = e;
            if (busy_u) bc_u++;
            if (busy_s) bc_s++;
            if (!done_u && prod_u !== exp_u) moved_u = 1'b1;
            if (!done_s && prod_s !== exp_s) moved_s = 1'b1;
            if (lat_u >= 0 && lat_s >= 0) break;
            @(negedge clk);
        end
        start = 1'b0;

        check("u_first_cycle", 32'(first_u), 32'b10);
        check("u_latency",     32'(lat_u),   32'(ku + 1));
        check("u_busy_cycles", 32'(bc_u),    32'(ku + 1));
        check("u_early_prod",  32'(moved_u), 32'd0);
        check("u_product",     32'(prod_u),  32'(new_u));
        check("s_first_cycle", 32'(first_s), 32'b10);
        check("s_latency",     32'(lat_s),   32'(ks + 1));
        check("s_busy_cycles", 32'(bc_s),    32'(ks + 1));
        check("s_early_prod",  32'(moved_s), 32'd0);
        check("s_product",     32'(prod_s),  32'(new_s));
        exp_u = new_u;
        exp_s = new_s;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; a_in = '0; b_in = '0;
        exp_u = '0; exp_s = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_busy_u", 32'(busy_u), 32'd0);
        check("rst_done_u", 32'(done_u), 32'd0);
        check("rst_prod_u", 32'(prod_u), 32'd0);
        check("rst_busy_s", 32'(busy_s), 32'd0);
        check("rst_done_s", 32'(done_s), 32'd0);
        check("rst_prod_s", 32'(prod_s), 32'd0);

        // Directed operand sets, including zero, all-ones and most-negative cases.
        run_op(8'd13, 8'd11, 1'b0);
        check("dir_13x11", 32'(prod_u), 32'h008F);
        run_op(8'd200, 8'd0, 1'b0);
        run_op(8'd255, 8'd255, 1'b0);
        check("dir_255x255", 32'(prod_u), 32'hFE01);
        run_op(8'hF9, 8'd5, 1'b0);
        check("dir_m7x5", 32'(prod_s), 32'hFFDD);
        run_op(8'h80, 8'h80, 1'b0);
        check("dir_m128xm128", 32'(prod_s), 32'h4000);
        run_op(8'h80, 8'd1, 1'b0);
        check("dir_m128x1", 32'(prod_s), 32'hFF80);

        // Back-to-back from DONE.
        run_op(8'd13, 8'd11, 1'b0);
        run_op(8'd3, 8'd3, 1'b0);
        check("b2b_3x3", 32'(prod_u), 32'd9);

        // Abort on the third CALC cycle, with start also high: abort wins.
        @(negedge clk);
        start = 1'b1; a_in = 8'd100; b_in = 8'd200;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        check("abort_busy_u", 32'(busy_u), 32'd0);
        check("abort_done_u", 32'(done_u), 32'd0);
        check("abort_prod_u", 32'(prod_u), 32'(exp_u));
        check("abort_busy_s", 32'(busy_s), 32'd0);
        check("abort_prod_s", 32'(prod_s), 32'(exp_s));
        @(negedge clk);
        check("abort_stays_idle", 32'({busy_u, done_u, busy_s, done_s}), 32'd0);

        // start pulsed during CALC must be ignored.
        run_op(8'd100, 8'd200, 1'b1);

        // Synchronous reset in the middle of CALC.
        @(negedge clk);
        start = 1'b1; a_in = 8'd77; b_in = 8'd99;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_u = '0;
        exp_s = '0;
        check("midrst_u", 32'({busy_u, done_u, prod_u}), 32'd0);
        check("midrst_s", 32'({busy_s, done_s, prod_s}), 32'd0);
        run_op(8'd77, 8'd99, 1'b0);

        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
            run_op(ra, rb, 1'($urandom_range(0, 1)) && (rb > 8'd1) && (rb < 8'h80));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
